// File: rtl/dmem_arbiter_if.sv
// Request/response bus between one requester and the data-memory arbiter.
//   master: requester side (drives req/rw/addr/wdata, receives gnt/rvalid/rdata/err)
//   slave : arbiter side (mirror of master)
interface dmem_arbiter_if;
    localparam int unsigned DATA_W = 32;

    logic              req;
    logic              rw;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, rw, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, rw, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the big-endian data RAM.
// Each transaction drives the memory bus for one cycle (ACCESS), then reports
// completion with registered read data for one cycle (RESP).
// Ports:
//   CLK, Reset        clock, asynchronous active-high reset
//   m0, m1            requester buses (slave side); port 0 = load/store unit, port 1 = debug/loader
//   mem_addr/rw/wdata memory bus, registered, zero when not in ACCESS
//   mem_rdata         memory read data, combinational from mem_addr
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic [31:0]       mem_addr,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    // Highest legal word address; a 33-bit compare against it also rejects
    // any address with bits above ADDR_W set.
    localparam logic [32:0] MAX_ADDR = 33'((64'd1 << ADDR_W) - 64'd4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic              last;      // port granted most recently
    logic              lat_port;
    logic              lat_rw;
    logic              lat_ok;

    logic              any_req;
    logic              win;
    logic              win_rw;
    logic [31:0]       win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_ok;
    logic [DATA_W-1:0] capture;

    // Round-robin winner and its request fields.
    always_comb begin
        any_req   = m0.req | m1.req;
        win       = (m0.req && m1.req) ? ~last : m1.req;
        win_rw    = win ? m1.rw    : m0.rw;
        win_addr  = win ? m1.addr  : m0.addr;
        win_wdata = win ? m1.wdata : m0.wdata;
        win_ok    = (win_addr[1:0] == 2'b00) && ({1'b0, win_addr} <= MAX_ADDR);
        capture   = (lat_ok && !lat_rw) ? mem_rdata : '0;
    end

    // Sequencer: state, latched request and all registered outputs.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            lat_port  <= 1'b0;
            lat_rw    <= 1'b0;
            lat_ok    <= 1'b0;
            m0.gnt    <= 1'b0;
            m0.rvalid <= 1'b0;
            m0.rdata  <= '0;
            m0.err    <= 1'b0;
            m1.gnt    <= 1'b0;
            m1.rvalid <= 1'b0;
            m1.rdata  <= '0;
            m1.err    <= 1'b0;
            mem_addr  <= '0;
            mem_rw    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    m0.rvalid <= 1'b0;
                    m0.rdata  <= '0;
                    m0.err    <= 1'b0;
                    m1.rvalid <= 1'b0;
                    m1.rdata  <= '0;
                    m1.err    <= 1'b0;
                    if (any_req) begin
                        state     <= ACCESS;
                        last      <= win;
                        lat_port  <= win;
                        lat_rw    <= win_rw;
                        lat_ok    <= win_ok;
                        m0.gnt    <= ~win;
                        m1.gnt    <= win;
                        // Rejected accesses leave the bus idle so memory is untouched.
                        mem_addr  <= win_ok ? win_addr : '0;
                        mem_rw    <= win_ok & win_rw;
                        mem_wdata <= win_ok ? win_wdata : '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    m0.gnt    <= 1'b0;
                    m1.gnt    <= 1'b0;
                    mem_addr  <= '0;
                    mem_rw    <= 1'b0;
                    mem_wdata <= '0;
                    m0.rvalid <= ~lat_port;
                    m0.rdata  <= lat_port ? '0 : capture;
                    m0.err    <= ~lat_port & ~lat_ok;
                    m1.rvalid <= lat_port;
                    m1.rdata  <= lat_port ? capture : '0;
                    m1.err    <= lat_port & ~lat_ok;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed transactions, a transaction-level
// reference model compared every cycle, and literal expectations.
module tb_dmem_arbiter;
    logic CLK = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    dmem_arbiter_if p0 ();
    dmem_arbiter_if p1 ();

    logic [31:0] mem_addr;
    logic        mem_rw;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .m0        (p0),
        .m1        (p1),
        .mem_addr  (mem_addr),
        .mem_rw    (mem_rw),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Big-endian byte RAM seen by the DUT.
    logic [7:0] ram [256];
    assign mem_rdata = {ram[mem_addr[7:0]], ram[mem_addr[7:0] + 8'd1],
                        ram[mem_addr[7:0] + 8'd2], ram[mem_addr[7:0] + 8'd3]};
    always @(posedge CLK) begin
        if (mem_rw) begin
            ram[mem_addr[7:0]]         <= mem_wdata[31:24];
            ram[mem_addr[7:0] + 8'd1]  <= mem_wdata[23:16];
            ram[mem_addr[7:0] + 8'd2]  <= mem_wdata[15:8];
            ram[mem_addr[7:0] + 8'd3]  <= mem_wdata[7:0];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [7:0]  shadow [256];
    bit          m_busy, m_resp_phase, m_owner, m_rw, m_ok;
    bit          m_last = 1'b1;
    logic [31:0] m_addr, m_wdata, m_rdata;

    function automatic logic [31:0] shadow_word(input logic [31:0] a);
        return {shadow[a], shadow[a + 1], shadow[a + 2], shadow[a + 3]};
    endfunction

    // A transaction spends one cycle on the bus, then one cycle reporting; a new
    // one may start whenever nothing is on the bus.
    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            m_busy = 1'b0; m_resp_phase = 1'b0; m_last = 1'b1;
        end else if (m_busy && !m_resp_phase) begin
            m_resp_phase = 1'b1;
            if (m_ok && m_rw) begin
                shadow[m_addr]     = m_wdata[31:24];
                shadow[m_addr + 1] = m_wdata[23:16];
                shadow[m_addr + 2] = m_wdata[15:8];
                shadow[m_addr + 3] = m_wdata[7:0];
            end
            m_rdata = (m_ok && !m_rw) ? shadow_word(m_addr) : 32'd0;
        end else if (p0.req || p1.req) begin
            m_owner = (p0.req && p1.req) ? !m_last : p1.req;
            m_last  = m_owner;
            m_busy  = 1'b1; m_resp_phase = 1'b0;
            m_rw    = m_owner ? p1.rw : p0.rw;
            m_addr  = m_owner ? p1.addr : p0.addr;
            m_wdata = m_owner ? p1.wdata : p0.wdata;
            m_ok    = (m_addr % 4 == 0) && (m_addr <= 32'd252);
        end else begin
            m_busy = 1'b0; m_resp_phase = 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        bit bus, rsp;
        bus = m_busy && !m_resp_phase;
        rsp = m_busy && m_resp_phase;
        check("m0_gnt",    32'(p0.gnt),    32'(bus && !m_owner));
        check("m1_gnt",    32'(p1.gnt),    32'(bus && m_owner));
        check("mem_addr",  mem_addr,       (bus && m_ok) ? m_addr : 32'd0);
        check("mem_rw",    32'(mem_rw),    32'(bus && m_ok && m_rw));
        check("mem_wdata", mem_wdata,      (bus && m_ok) ? m_wdata : 32'd0);
        check("m0_rvalid", 32'(p0.rvalid), 32'(rsp && !m_owner));
        check("m1_rvalid", 32'(p1.rvalid), 32'(rsp && m_owner));
        check("m0_rdata",  p0.rdata,       (rsp && !m_owner) ? m_rdata : 32'd0);
        check("m1_rdata",  p1.rdata,       (rsp && m_owner) ? m_rdata : 32'd0);
        check("m0_err",    32'(p0.err),    32'(rsp && !m_owner && !m_ok));
        check("m1_err",    32'(p1.err),    32'(rsp && m_owner && !m_ok));
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit port, input bit req, input bit rw,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1.req = req; p1.rw = rw; p1.addr = addr; p1.wdata = wdata;
        end else begin
            p0.req = req; p0.rw = rw; p0.addr = addr; p0.wdata = wdata;
        end
    endtask

    task automatic reset_dut();
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
    endtask

    // One transaction; called and returns 1 time unit after a rising edge.
    task automatic txn(input bit port, input bit rw, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output logic g_rw, output logic [31:0] g_addr,
                       output int lat);
        int t0;
        bit seen;
        rdata = '0; err = 1'b0; g_rw = 1'b0; g_addr = '0; lat = -1;
        t0 = cyc;
        drive(port, 1'b1, rw, addr, wdata);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge CLK);
            if (port ? p1.gnt : p0.gnt) begin
                seen = 1'b1; g_rw = mem_rw; g_addr = mem_addr;
            end
        end
        drive(port, 1'b0, 1'b0, '0, '0);
        if (!seen) check("gnt_timeout", 32'd0, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge CLK);
            if (port ? p1.rvalid : p0.rvalid) begin
                seen = 1'b1;
                rdata = port ? p1.rdata : p0.rdata;
                err = port ? p1.err : p0.err;
                lat = cyc - t0;
            end
        end
        if (!seen) check("rvalid_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [31:0] rd, ga;
        logic        er, gr;
        int          lat;
        int          g0, g1, seen_rv;
        logic [31:0] rd0, rd1;
        bit          gnt_order[$];
        int          gnt_cyc[$];

        for (int i = 0; i < 256; i++) begin
            ram[i]    <= 8'(i) ^ 8'h5A;
            shadow[i]  = 8'(i) ^ 8'h5A;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_m0_gnt", 32'(p0.gnt), 32'd0);
        check("rst_m1_rvalid", 32'(p1.rvalid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_rw", 32'(mem_rw), 32'd0);
        @(posedge CLK);
        #1 Reset = 1'b0;
        @(posedge CLK);
        #1;

        // Port 0 write then read-back
        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, gr, ga, lat);
        check("wr10_mem_rw", 32'(gr), 32'd1);
        check("wr10_mem_addr", ga, 32'h10);
        check("wr10_err", 32'(er), 32'd0);
        check("wr10_latency", 32'(lat), 32'd2);
        txn(1'b0, 1'b0, 32'h10, 32'h0, rd, er, gr, ga, lat);
        check("rd10_data", rd, 32'hDEADBEEF);
        check("rd10_err", 32'(er), 32'd0);
        check("rd10_latency", 32'(lat), 32'd2);

        // Simultaneous reads right after reset: port 0 first, then port 1
        reset_dut();
        drive(1'b0, 1'b1, 1'b0, 32'h00, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h04, 32'h0);
        g0 = -1; g1 = -1; rd0 = '0; rd1 = '0; seen_rv = 0;
        for (int i = 0; i < 20 && seen_rv < 2; i++) begin
            @(negedge CLK);
            if (p0.gnt) begin g0 = cyc; p0.req = 1'b0; end
            if (p1.gnt) begin g1 = cyc; p1.req = 1'b0; end
            if (p0.rvalid) begin rd0 = p0.rdata; seen_rv++; end
            if (p1.rvalid) begin rd1 = p1.rdata; seen_rv++; end
        end
        check("tie_both_completed", 32'(seen_rv), 32'd2);
        check("tie_port0_first", 32'(g0 >= 0 && g0 < g1), 32'd1);
        check("tie_grant_gap", 32'(g1 - g0), 32'd2);
        check("tie_rd0", rd0, 32'h5A5B5859);
        check("tie_rd1", rd1, 32'h5E5F5C5D);
        @(posedge CLK);
        #1;

        // Misaligned write on port 1 is rejected; memory unchanged
        txn(1'b1, 1'b1, 32'h13, 32'hCAFEF00D, rd, er, gr, ga, lat);
        check("mis_mem_rw", 32'(gr), 32'd0);
        check("mis_err", 32'(er), 32'd1);
        check("mis_rdata", rd, 32'd0);
        txn(1'b0, 1'b0, 32'h10, 32'h0, rd, er, gr, ga, lat);
        check("mis_rd10", rd, 32'hDEADBEEF);

        // Range boundary
        txn(1'b0, 1'b0, 32'h100, 32'h0, rd, er, gr, ga, lat);
        check("oor_err", 32'(er), 32'd1);
        check("oor_rdata", rd, 32'd0);
        txn(1'b0, 1'b0, 32'hFC, 32'h0, rd, er, gr, ga, lat);
        check("top_err", 32'(er), 32'd0);
        check("top_rdata", rd, 32'hA6A7A4A5);

        // Reset during the ACCESS cycle of a write
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h11223344);
        g0 = -1;
        for (int i = 0; i < 8 && g0 < 0; i++) begin
            @(negedge CLK);
            if (p0.gnt) g0 = cyc;
        end
        check("abort_gnt_seen", 32'(g0 >= 0), 32'd1);
        #2;
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        check("abort_m0_gnt", 32'(p0.gnt), 32'd0);
        check("abort_mem_rw", 32'(mem_rw), 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_m0_rvalid", 32'(p0.rvalid), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1 Reset = 1'b0;
        seen_rv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (p0.rvalid) seen_rv++;
        end
        check("abort_no_rvalid", 32'(seen_rv), 32'd0);
        @(posedge CLK);
        #1;
        txn(1'b0, 1'b0, 32'h20, 32'h0, rd, er, gr, ga, lat);
        check("abort_rd20", rd, 32'h7A7B7879);

        // Continuous requests from both ports
        drive(1'b0, 1'b1, 1'b0, 32'h08, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0C, 32'h0);
        for (int i = 0; i < 40 && gnt_order.size() < 10; i++) begin
            @(negedge CLK);
            if (p0.gnt || p1.gnt) begin
                gnt_order.push_back(p1.gnt);
                gnt_cyc.push_back(cyc);
            end
            check("cont_rvalid_exclusive", 32'(p0.rvalid && p1.rvalid), 32'd0);
            check("cont_rw_in_resp", 32'(mem_rw && (p0.rvalid || p1.rvalid)), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        check("cont_grant_count", 32'(gnt_order.size()), 32'd10);
        for (int i = 1; i < gnt_order.size(); i++) begin
            check("cont_alternate", 32'(gnt_order[i] != gnt_order[i-1]), 32'd1);
            check("cont_gap", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd2);
        end
        repeat (4) @(posedge CLK);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
